// File: rtl/imu_spi_responder_if.sv
// -----------------------------------------------------------------------------
// imu_spi_responder_if
//   SPI pin bundle between the IMU-read master and the responder.
//   CS     : chip select, active low (master -> slave)
//   SPC    : SPI clock, idle high, mode 3 (master -> slave)
//   SDI    : master-out data (master -> slave)
//   SDO    : slave-out data (slave -> master)
//   sdo_oe : SDO output enable, high during a read data phase (slave -> master)
// -----------------------------------------------------------------------------
interface imu_spi_responder_if;
  logic CS;
  logic SPC;
  logic SDI;
  logic SDO;
  logic sdo_oe;

  modport master (output CS, output SPC, output SDI, input SDO, input sdo_oe);
  modport slave  (input CS, input SPC, input SDI, output SDO, output sdo_oe);
endinterface

// File: rtl/imu_spi_responder.sv
// -----------------------------------------------------------------------------
// imu_spi_responder
//   SPI slave (mode 3) fronting a small IMU register map. All SPI pins are
//   oversampled in the clk domain; nothing is clocked by SPC.
//   Optional feature macro: ADDR_AUTOINC_EN (MS bit enables address
//   auto-increment after each data byte; when undefined MS is ignored).
// Ports
//   clk, rst_n    : system clock (>= 8x SPC), asynchronous active-low reset
//   spi (slave)   : CS, SPC, SDI in; SDO, sdo_oe out
//   sample_data   : {Z,Y,X} 16-bit samples, loaded on sample_valid
//   sample_valid  : one-cycle strobe updating the live sample registers
//   ctrl_reg      : current value of register 0x20
//   wr_strobe     : one-cycle pulse after each accepted register write
//   busy          : high while a frame is in progress
// Register map: 0x0F WHO_AM_I, 0x20..0x27 control (RW), 0x28..0x2D shadow
// X_L..Z_H (RO); everything else reads 8'h00. Addresses wrap at 6 bits.
// -----------------------------------------------------------------------------
module imu_spi_responder #(
  parameter logic [7:0] WHO_AM_I = 8'h68,
  parameter int         SYNC_STG = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  imu_spi_responder_if.slave        spi,
  input  logic [47:0]               sample_data,
  input  logic                      sample_valid,
  output logic [7:0]                ctrl_reg,
  output logic                      wr_strobe,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STG-1:0]   cs_sync_q, cs_sync_d;
  logic [SYNC_STG-1:0]   spc_sync_q, spc_sync_d;
  logic [SYNC_STG-1:0]   sdi_sync_q, sdi_sync_d;
  logic                  cs_prev_q, cs_prev_d;
  logic                  spc_prev_q, spc_prev_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [5:0]            addr_q, addr_d;
  logic                  ms_q, ms_d;
  logic [7:0]            sh_in_q, sh_in_d;
  logic [7:0]            sh_out_q, sh_out_d;
  logic                  sdo_q, sdo_d;
  logic                  sdo_oe_q, sdo_oe_d;
  logic                  busy_q, busy_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [7:0][7:0]       ctrl_q, ctrl_d;
  logic [47:0]           live_q, live_d;
  logic [47:0]           shadow_q, shadow_d;

  logic                  cs_s, spc_s, sdi_s;
  logic                  cs_fall_s, cs_rise_s, spc_rise_s, spc_fall_s;
  logic [7:0]            in_byte_s;
  logic [5:0]            next_addr_s;

  // Register-map read decode; the shadow copy is used so a frame stays coherent.
  function automatic logic [7:0] reg_read(input logic [5:0] a,
                                          input logic [7:0][7:0] ctrl,
                                          input logic [47:0] shadow);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      6'h0F:                             r = WHO_AM_I;
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27:        r = ctrl[a[2:0]];
      6'h28:                             r = shadow[7:0];
      6'h29:                             r = shadow[15:8];
      6'h2A:                             r = shadow[23:16];
      6'h2B:                             r = shadow[31:24];
      6'h2C:                             r = shadow[39:32];
      6'h2D:                             r = shadow[47:40];
      default:                           r = 8'h00;
    endcase
    return r;
  endfunction

  assign cs_s       = cs_sync_q[SYNC_STG-1];
  assign spc_s      = spc_sync_q[SYNC_STG-1];
  assign sdi_s      = sdi_sync_q[SYNC_STG-1];
  assign cs_fall_s  = cs_prev_q & ~cs_s;
  assign cs_rise_s  = ~cs_prev_q & cs_s;
  assign spc_rise_s = ~spc_prev_q & spc_s;
  assign spc_fall_s = spc_prev_q & ~spc_s;
  // Byte as it stands once the current SPC-rise bit is shifted in.
  assign in_byte_s  = {sh_in_q[6:0], sdi_s};

`ifdef ADDR_AUTOINC_EN
  assign next_addr_s = ms_q ? (addr_q + 6'd1) : addr_q;
`else
  logic unused_ms_s;
  assign unused_ms_s = ms_q;
  assign next_addr_s = addr_q;
`endif

  assign spi.SDO    = sdo_q;
  assign spi.sdo_oe = sdo_oe_q;
  assign ctrl_reg   = ctrl_q[0];
  assign wr_strobe  = wr_strobe_q;
  assign busy       = busy_q;

  // Next-state logic: synchronizers, frame FSM, register file and outputs.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STG-2:0], spi.CS};
    spc_sync_d  = {spc_sync_q[SYNC_STG-2:0], spi.SPC};
    sdi_sync_d  = {sdi_sync_q[SYNC_STG-2:0], spi.SDI};
    cs_prev_d   = cs_s;
    spc_prev_d  = spc_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    ms_d        = ms_q;
    sh_in_d     = sh_in_q;
    sh_out_d    = sh_out_q;
    sdo_d       = sdo_q;
    busy_d      = ~cs_s;
    wr_strobe_d = 1'b0;
    ctrl_d      = ctrl_q;
    shadow_d    = shadow_q;
    if (sample_valid) begin
      live_d = sample_data;
    end else begin
      live_d = live_q;
    end

    if (cs_rise_s) begin
      // CS deassertion aborts whatever is in flight; partial bytes are lost.
      state_d   = IDLE;
      sdo_d     = 1'b1;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            state_d   = CMD;
            shadow_d  = live_q;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (spc_rise_s) begin
            sh_in_d   = in_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = in_byte_s[5:0];
              ms_d   = in_byte_s[6];
              if (in_byte_s[7]) begin
                state_d  = RD;
                sh_out_d = reg_read(in_byte_s[5:0], ctrl_q, shadow_q);
              end else begin
                state_d = WR;
              end
            end else begin
              state_d = CMD;
            end
          end else begin
            state_d = CMD;
          end
        end
        RD: begin
          if (spc_fall_s) begin
            sdo_d     = sh_out_q[7];
            sh_out_d  = {sh_out_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            // Last bit of the byte is on the wire: preload the following byte.
            if (bit_cnt_q == 3'd7) begin
              addr_d   = next_addr_s;
              sh_out_d = reg_read(next_addr_s, ctrl_q, shadow_q);
            end else begin
              addr_d = addr_q;
            end
          end else begin
            sdo_d = sdo_q;
          end
        end
        WR: begin
          if (spc_rise_s) begin
            sh_in_d   = in_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Only the control block 0x20..0x27 is writable.
              if (addr_q[5:3] == 3'b100) begin
                ctrl_d[addr_q[2:0]] = in_byte_s;
                wr_strobe_d         = 1'b1;
              end else begin
                wr_strobe_d = 1'b0;
              end
              addr_d = next_addr_s;
            end else begin
              addr_d = addr_q;
            end
          end else begin
            sh_in_d = sh_in_q;
          end
        end
        default: begin
          state_d = IDLE;
          sdo_d   = 1'b1;
        end
      endcase
    end
    sdo_oe_d = (state_d == RD);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= {SYNC_STG{1'b1}};
      spc_sync_q  <= {SYNC_STG{1'b1}};
      sdi_sync_q  <= {SYNC_STG{1'b0}};
      cs_prev_q   <= 1'b1;
      spc_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      addr_q      <= 6'd0;
      ms_q        <= 1'b0;
      sh_in_q     <= 8'h00;
      sh_out_q    <= 8'h00;
      sdo_q       <= 1'b1;
      sdo_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      ctrl_q      <= 64'h0;
      live_q      <= 48'h0;
      shadow_q    <= 48'h0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      spc_sync_q  <= spc_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      cs_prev_q   <= cs_prev_d;
      spc_prev_q  <= spc_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      ms_q        <= ms_d;
      sh_in_q     <= sh_in_d;
      sh_out_q    <= sh_out_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      ctrl_q      <= ctrl_d;
      live_q      <= live_d;
      shadow_q    <= shadow_d;
    end
  end

endmodule

// File: tb/tb_imu_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_imu_spi_responder
//   Mode-3 SPI master driving imu_spi_responder: a table of single-byte
//   frames with hand-derived expectations, hand-written multi-byte/abort/
//   coherency sequences, then randomized frames checked against a register-map
//   model kept at frame level.
// -----------------------------------------------------------------------------
module tb_imu_spi_responder;

  localparam int H = 8;  // clk cycles per SPC half period

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] sample_data;
  logic        sample_valid;
  logic [7:0]  ctrl_reg;
  logic        wr_strobe;
  logic        busy;

  imu_spi_responder_if spi();

  imu_spi_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .ctrl_reg     (ctrl_reg),
    .wr_strobe    (wr_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;

  // Count every clk cycle wr_strobe is high; a clean write adds exactly one.
  always @(posedge clk) if (wr_strobe) strobe_cnt <= strobe_cnt + 1;

  logic [7:0]  tx_buf [0:7];
  logic [7:0]  rx_buf [0:7];
  logic [7:0]  exp_buf [0:7];

  // Reference model state
  logic [7:0]  m_ctrl [0:7];
  logic [15:0] m_live [0:2];
  logic [15:0] m_shadow [0:2];
  int          m_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    int idx;
    if (a == 15) return 8'h68;
    if (a >= 32 && a <= 39) return m_ctrl[a - 32];
    if (a >= 40 && a <= 45) begin
      idx = a - 40;
      if (idx % 2 == 1) return m_shadow[idx / 2][15:8];
      return m_shadow[idx / 2][7:0];
    end
    return 8'h00;
  endfunction

  // Frame-level model: nfull complete bytes (cmd included) as held in tx_buf.
  task automatic model_frame(input int nfull);
    int a;
    m_strb = 0;
    for (int k = 0; k < 3; k++) m_shadow[k] = m_live[k];
    a = int'(tx_buf[0][5:0]);
    for (int i = 1; i < nfull; i++) begin
      if (tx_buf[0][7]) exp_buf[i] = m_read(a);
      else if (a >= 32 && a <= 39) begin
        m_ctrl[a - 32] = tx_buf[i];
        m_strb++;
      end
`ifdef ADDR_AUTOINC_EN
      if (tx_buf[0][6]) a = (a + 1) % 64;
`endif
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_data  = {z, y, x};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_live[0] = x; m_live[1] = y; m_live[2] = z;
  endtask

  // Drive one frame of nbits bits from tx_buf, capture SDO into rx_buf.
  task automatic xfer(input int nbits, input bit rd, input bit mid_sv,
                      input logic [15:0] mid_x, output int oe_err);
    oe_err = 0;
    spi.CS = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      if (mid_sv && b == 8) pulse_sample(mid_x, m_live[1], m_live[2]);
      spi.SPC = 1'b0;
      spi.SDI = tx_buf[b / 8][7 - (b % 8)];
      repeat (H) @(negedge clk);
      if (b == 0) check("busy in frame", busy, 1);
      rx_buf[b / 8][7 - (b % 8)] = spi.SDO;
      if ((rd && b >= 8) != spi.sdo_oe) oe_err++;
      spi.SPC = 1'b1;
      repeat (H) @(negedge clk);
    end
    spi.CS = 1'b1;
    repeat (6) @(negedge clk);
    check("SDO idle after CS", spi.SDO, 1);
    check("sdo_oe after CS", spi.sdo_oe, 0);
    check("busy after CS", busy, 0);
  endtask

  // Model-checked frame; returns the observed strobe delta for extra checks.
  task automatic run_frame(input int nbits, input bit mid_sv, input logic [15:0] mid_x,
                           output int strb_delta);
    int s0, oe_err;
    model_frame(nbits / 8);
    s0 = strobe_cnt;
    xfer(nbits, tx_buf[0][7], mid_sv, mid_x, oe_err);
    strb_delta = strobe_cnt - s0;
    check("sdo_oe window", oe_err, 0);
    check("wr_strobe count", strb_delta, m_strb);
    check("ctrl_reg", ctrl_reg, m_ctrl[0]);
    if (tx_buf[0][7])
      for (int i = 1; i < nbits / 8; i++) check("read byte vs model", rx_buf[i], exp_buf[i]);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_strb;
    logic [7:0] exp_ctrl0;
  } vec_t;

  vec_t vt [0:11];
  logic [7:0] exp6 [0:5];

  initial begin
    int d;
    logic [5:0] ra;
    int nb;

    vt[0]  = '{8'h8F, 8'h00, 8'h68, 0, 8'h00};
    vt[1]  = '{8'h20, 8'h5A, 8'h00, 1, 8'h5A};
    vt[2]  = '{8'hA0, 8'h00, 8'h5A, 0, 8'h5A};
    vt[3]  = '{8'h0F, 8'hFF, 8'h00, 0, 8'h5A};
    vt[4]  = '{8'h8F, 8'h00, 8'h68, 0, 8'h5A};
    vt[5]  = '{8'h27, 8'h3C, 8'h00, 1, 8'h5A};
    vt[6]  = '{8'hA7, 8'h00, 8'h3C, 0, 8'h5A};
    vt[7]  = '{8'hA8, 8'h00, 8'h00, 0, 8'h5A};
    vt[8]  = '{8'h3F, 8'h11, 8'h00, 0, 8'h5A};
    vt[9]  = '{8'hBF, 8'h00, 8'h00, 0, 8'h5A};
    vt[10] = '{8'h1F, 8'hAA, 8'h00, 0, 8'h5A};
    vt[11] = '{8'h80, 8'h00, 8'h00, 0, 8'h5A};

    for (int k = 0; k < 8; k++) m_ctrl[k] = 8'h00;
    for (int k = 0; k < 3; k++) begin m_live[k] = 16'h0; m_shadow[k] = 16'h0; end

    spi.CS = 1'b1; spi.SPC = 1'b1; spi.SDI = 1'b0;
    sample_data = 48'h0; sample_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset SDO", spi.SDO, 1);
    check("reset sdo_oe", spi.sdo_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset ctrl_reg", ctrl_reg, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table of single-data-byte frames
    for (int v = 0; v < 12; v++) begin
      tx_buf[0] = vt[v].cmd;
      tx_buf[1] = vt[v].wdata;
      run_frame(16, 1'b0, 16'h0, d);
      if (vt[v].cmd[7]) check("table read", rx_buf[1], vt[v].exp_rd);
      check("table strobe", d, vt[v].exp_strb);
      check("table ctrl_reg", ctrl_reg, vt[v].exp_ctrl0);
    end

    // Six-byte read of the sample block with MS set
    pulse_sample(16'h1234, 16'hABCD, 16'h8001);
`ifdef ADDR_AUTOINC_EN
    exp6 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
`else
    exp6 = '{8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34};
`endif
    tx_buf[0] = 8'hE8;
    for (int i = 1; i < 7; i++) tx_buf[i] = 8'h00;
    run_frame(56, 1'b0, 16'h0, d);
    for (int i = 0; i < 6; i++) check("burst sample read", rx_buf[i + 1], exp6[i]);

    // Coherency: new X mid-frame is only seen by the next frame
    pulse_sample(16'h5555, 16'hABCD, 16'h8001);
    tx_buf[0] = 8'hA8;
    run_frame(24, 1'b1, 16'h7777, d);
    check("mid-frame old X byte1", rx_buf[1], 8'h55);
    check("mid-frame old X byte2", rx_buf[2], 8'h55);
    run_frame(16, 1'b0, 16'h0, d);
    check("next frame new X", rx_buf[1], 8'h77);

    // Abort after 5 data bits of a write to 0x21
    tx_buf[0] = 8'h21; tx_buf[1] = 8'hFF;
    run_frame(13, 1'b0, 16'h0, d);
    check("abort no strobe", d, 0);
    tx_buf[0] = 8'hA1; tx_buf[1] = 8'h00;
    run_frame(16, 1'b0, 16'h0, d);
    check("abort reg unchanged", rx_buf[1], 8'h00);

    // Randomized frames against the model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3) == 0)
        pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      case ($urandom_range(3))
        0: ra = 6'($urandom);
        1: ra = 6'h0F;
        2: ra = 6'h20 + 6'($urandom_range(7));
        default: ra = 6'h28 + 6'($urandom_range(5));
      endcase
      tx_buf[0] = {1'($urandom), 1'($urandom), ra};
      nb = $urandom_range(5, 2);
      for (int i = 1; i < 8; i++) tx_buf[i] = 8'($urandom);
      run_frame(nb * 8, 1'b0, 16'h0, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
